led_pwm_fader: RTL and testbench

- Downstream consumer of the variable-rate LED blink stage.
- Takes that stage's square-wave output as a rate tick and drives a physical LED with a PWM "breathing" pattern: ramp up, hold bright, ramp down, hold dark.
- Single clock domain, shared with the blink stage.
- Its output replaces the raw blink signal at the board LED pin.

---
 rtl/led_pwm_fader_pkg.sv | 22 ++
 rtl/led_pwm_fader_pwm_core.sv | 73 +++++++
 rtl/led_pwm_fader.sv | 131 +++++++++++++
 tb/tb_led_pwm_fader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_fader_pkg.sv
// Shared definitions for the LED PWM fader.
//   PhaseW      : width of the phase/state encoding
//   phase_e     : fader FSM states, values match the external phase output
//   rise_detect : single-cycle rising-edge helper for same-domain rate ticks
package led_pwm_fader_pkg;

  localparam int unsigned PhaseW = 3;

  typedef enum logic [PhaseW-1:0] {
    StIdle     = 3'd0,
    StRampUp   = 3'd1,
    StHoldHi   = 3'd2,
    StRampDown = 3'd3,
    StHoldLo   = 3'd4
  } phase_e;

  // cur is the live signal, prev its registered copy.
  function automatic logic rise_detect(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/led_pwm_fader_pwm_core.sv
// PWM generator for the LED fader.
//   clk, reset_n  : clock, asynchronous active-low reset
//   clear         : forces duty_active to 0 on the next cycle, bypassing the period boundary
//   duty_target   : duty requested by the fader FSM, sampled at each period boundary
//   duty_active   : duty currently applied to the comparator
//   led_out       : registered PWM output, high while pwm_cnt < duty_active
//   period_start  : one-cycle pulse in the cycle after pwm_cnt wraps MAX -> 0
module led_pwm_fader_pwm_core #(
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [PWM_BITS-1:0] duty_target,
  output logic [PWM_BITS-1:0] duty_active,
  output logic                led_out,
  output logic                period_start
);

  localparam logic [PWM_BITS-1:0] CntMax = '1;

  logic                advance;
  logic                wrap;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_active_q;
  logic                led_q;
  logic                period_start_q;

  if (PRESCALE_BITS == 0) begin : g_no_presc
    assign advance = 1'b1;
  end else begin : g_presc
    logic [PRESCALE_BITS-1:0] presc_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end

    assign advance = &presc_q;
  end

  assign wrap = advance && (pwm_cnt_q == CntMax);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q      <= '0;
      duty_active_q  <= '0;
      led_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      if (advance) begin
        pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
      // Disable takes effect immediately rather than waiting for the boundary.
      if (clear) begin
        duty_active_q <= '0;
      end else if (wrap) begin
        duty_active_q <= duty_target;
      end
      led_q          <= (pwm_cnt_q < duty_active_q);
      period_start_q <= wrap;
    end
  end

  assign duty_active  = duty_active_q;
  assign led_out      = led_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/led_pwm_fader.sv
// LED "breathing" fader: ramps PWM duty up, holds bright, ramps down, holds dark,
// stepping once per rising edge of the blink-stage tick.
//   clk, reset_n  : clock, asynchronous active-low reset
//   en            : fader enable (level); low forces IDLE and a dark LED
//   tick_in       : rate signal from the blink stage, rising edges only
//   led_out       : PWM LED drive
//   duty          : duty currently applied
//   phase         : FSM state (0 IDLE, 1 RAMP_UP, 2 HOLD_HI, 3 RAMP_DOWN, 4 HOLD_LO)
//   period_start  : one-cycle pulse at each PWM period start
module led_pwm_fader
  import led_pwm_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE_BITS = 4,
  parameter int unsigned STEP          = 8,
  parameter int unsigned HOLD_TICKS    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                tick_in,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [PhaseW-1:0]   phase,
  output logic                period_start
);

  localparam logic [PWM_BITS-1:0] DutyMax  = '1;
  localparam logic [PWM_BITS:0]   StepExt  = (PWM_BITS + 1)'(STEP);
  localparam logic [7:0]          HoldLast = 8'(HOLD_TICKS);

  phase_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_target_q, duty_target_d;
  logic [7:0]          hold_cnt_q, hold_cnt_d;
  logic                tick_q;
  logic                tick_rise;
  logic [PWM_BITS:0]   duty_sum;

  assign tick_rise = rise_detect(tick_in, tick_q);
  // One bit wider so the ramp-up saturation test sees the carry.
  assign duty_sum  = {1'b0, duty_target_q} + StepExt;

  always_comb begin
    state_d       = state_q;
    duty_target_d = duty_target_q;
    hold_cnt_d    = hold_cnt_q;
    if (!en) begin
      state_d       = StIdle;
      duty_target_d = '0;
      hold_cnt_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          duty_target_d = '0;
          state_d       = StRampUp;
        end
        StRampUp: begin
          if (tick_rise) begin
            if (duty_sum >= {1'b0, DutyMax}) begin
              duty_target_d = DutyMax;
              hold_cnt_d    = '0;
              state_d       = StHoldHi;
            end else begin
              duty_target_d = duty_sum[PWM_BITS-1:0];
            end
          end
        end
        StHoldHi: begin
          if (tick_rise) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
            if (hold_cnt_q + 8'd1 == HoldLast) begin
              state_d = StRampDown;
            end
          end
        end
        StRampDown: begin
          if (tick_rise) begin
            if ({1'b0, duty_target_q} <= StepExt) begin
              duty_target_d = '0;
              hold_cnt_d    = '0;
              state_d       = StHoldLo;
            end else begin
              duty_target_d = duty_target_q - StepExt[PWM_BITS-1:0];
            end
          end
        end
        StHoldLo: begin
          if (tick_rise) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
            if (hold_cnt_q + 8'd1 == HoldLast) begin
              state_d = StRampUp;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      duty_target_q <= '0;
      hold_cnt_q    <= '0;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_target_q <= duty_target_d;
      hold_cnt_q    <= hold_cnt_d;
      tick_q        <= tick_in;
    end
  end

  led_pwm_fader_pwm_core #(
    .PWM_BITS      (PWM_BITS),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_pwm_core (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (~en),
    .duty_target  (duty_target_q),
    .duty_active  (duty),
    .led_out      (led_out),
    .period_start (period_start)
  );

  assign phase = state_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       tick_in = 1'b0;
  logic       led_out;
  logic [3:0] duty;
  logic [2:0] phase;
  logic       period_start;

  int vectors = 0;
  int miscompares = 0;
  int bad_steps = 0;
  logic [3:0] prev_duty = '0;

  led_pwm_fader #(
    .PWM_BITS      (4),
    .PRESCALE_BITS (0),
    .STEP          (4),
    .HOLD_TICKS    (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .tick_in      (tick_in),
    .led_out      (led_out),
    .duty         (duty),
    .phase        (phase),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge; note any duty change off a period_start cycle.
  task automatic step_cycle();
    @(negedge clk);
    if (duty !== prev_duty && period_start !== 1'b1) bad_steps++;
    prev_duty = duty;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  // One rising tick edge, then enough cycles for a period boundary to pass.
  task automatic tick_and_settle();
    tick_in = 1'b1;
    run(4);
    tick_in = 1'b0;
    run(20);
  endtask

  task automatic wait_period_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step_cycle();
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int last;
    int pulses;
    reset_n = 1'b0;
    en = 1'b0;
    tick_in = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(30);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({led_out, duty, phase, period_start} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_assert: led=%b duty=%0d phase=%0d ps=%b, want all 0",
               led_out, duty, phase, period_start);
    end
    run(3);
    reset_n = 1'b1;
    last = -1;
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 3 == 0) tick_in = ~tick_in;
      step_cycle();
      vectors++;
      if ({led_out, duty, phase} !== 8'd0) begin
        miscompares++;
        $display("FAIL idle_outputs cyc %0d: led=%b duty=%0d phase=%0d, want 0 0 0",
                 i, led_out, duty, phase);
      end
      if (period_start === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (i - last != 16) begin
            miscompares++;
            $display("FAIL period_interval: got %0d cycles, want 16", i - last);
          end
        end
        last = i;
        pulses++;
      end
    end
    tick_in = 1'b0;
    vectors++;
    if (pulses < 3) begin
      miscompares++;
      $display("FAIL period_pulses: got %0d pulses in 64 cycles, want >= 3", pulses);
    end
  endtask

  task automatic test_ramp_up();
    logic [3:0] exp_duty [4] = '{4'd4, 4'd8, 4'd12, 4'd15};
    logic [2:0] exp_phase [4] = '{3'd1, 3'd1, 3'd1, 3'd2};
    bit ok;
    int hi;
    en = 1'b1;
    step_cycle();
    vectors++;
    if (phase !== 3'd1) begin
      miscompares++;
      $display("FAIL enable_phase: got %0d, want 1", phase);
    end
    prev_duty = duty;
    bad_steps = 0;
    for (int i = 0; i < 4; i++) begin
      tick_and_settle();
      vectors++;
      if (duty !== exp_duty[i] || phase !== exp_phase[i]) begin
        miscompares++;
        $display("FAIL ramp_up edge %0d: duty=%0d phase=%0d, want duty=%0d phase=%0d",
                 i, duty, phase, exp_duty[i], exp_phase[i]);
      end
      wait_period_start(ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL ramp_up period_start timeout: got none in 40 cycles, want one");
      end
      hi = 0;
      for (int c = 0; c < 16; c++) begin
        step_cycle();
        if (led_out === 1'b1) hi++;
      end
      vectors++;
      if (hi != int'(exp_duty[i])) begin
        miscompares++;
        $display("FAIL ramp_up led_high edge %0d: got %0d/16, want %0d/16", i, hi, exp_duty[i]);
      end
    end
    vectors++;
    if (bad_steps != 0) begin
      miscompares++;
      $display("FAIL ramp_up off_boundary_steps: got %0d, want 0", bad_steps);
    end
  endtask

  task automatic test_full_cycle();
    logic [3:0] exp_duty [8] = '{4'd15, 4'd15, 4'd11, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0};
    logic [2:0] exp_phase [8] = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd1};
    bad_steps = 0;
    for (int i = 0; i < 8; i++) begin
      tick_and_settle();
      vectors++;
      if (duty !== exp_duty[i] || phase !== exp_phase[i]) begin
        miscompares++;
        $display("FAIL full_cycle edge %0d: duty=%0d phase=%0d, want duty=%0d phase=%0d",
                 i, duty, phase, exp_duty[i], exp_phase[i]);
      end
    end
    vectors++;
    if (bad_steps != 0) begin
      miscompares++;
      $display("FAIL full_cycle off_boundary_steps: got %0d, want 0", bad_steps);
    end
  endtask

  task automatic test_edge_only();
    tick_in = 1'b1;
    run(100);
    tick_in = 1'b0;
    run(20);
    vectors++;
    if (duty !== 4'd4 || phase !== 3'd1) begin
      miscompares++;
      $display("FAIL edge_only: duty=%0d phase=%0d, want duty=4 phase=1", duty, phase);
    end
  endtask

  task automatic test_boundary_collision();
    bit ok;
    wait_period_start(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL collision period_start timeout: got none, want one");
    end
    // pwm_cnt is 15 fifteen cycles after the period_start cycle.
    run(15);
    tick_in = 1'b1;
    step_cycle();
    vectors++;
    if (period_start !== 1'b1 || duty !== 4'd4) begin
      miscompares++;
      $display("FAIL collision boundary: ps=%b duty=%0d, want ps=1 duty=4", period_start, duty);
    end
    run(3);
    tick_in = 1'b0;
    run(12);
    step_cycle();
    vectors++;
    if (period_start !== 1'b1 || duty !== 4'd8) begin
      miscompares++;
      $display("FAIL collision next_boundary: ps=%b duty=%0d, want ps=1 duty=8",
               period_start, duty);
    end
  endtask

  task automatic test_disable_priority();
    tick_and_settle();
    vectors++;
    if (duty !== 4'd12) begin
      miscompares++;
      $display("FAIL disable setup: duty=%0d, want 12", duty);
    end
    en = 1'b0;
    tick_in = 1'b1;
    step_cycle();
    vectors++;
    if (phase !== 3'd0 || duty !== 4'd0) begin
      miscompares++;
      $display("FAIL disable next_cycle: phase=%0d duty=%0d, want 0 0", phase, duty);
    end
    step_cycle();
    vectors++;
    if (led_out !== 1'b0) begin
      miscompares++;
      $display("FAIL disable led: got %b, want 0", led_out);
    end
    tick_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_cycle();
      vectors++;
      if ({led_out, duty, phase} !== 8'd0) begin
        miscompares++;
        $display("FAIL disabled_hold cyc %0d: led=%b duty=%0d phase=%0d, want 0 0 0",
                 i, led_out, duty, phase);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    en = 1'b1;
    run(2);
    tick_and_settle();
    vectors++;
    if (duty !== 4'd4 || phase !== 3'd1) begin
      miscompares++;
      $display("FAIL mid_ramp setup: duty=%0d phase=%0d, want 4 1", duty, phase);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({led_out, duty, phase} !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_ramp reset: led=%b duty=%0d phase=%0d, want 0 0 0",
               led_out, duty, phase);
    end
    run(2);
    reset_n = 1'b1;
    step_cycle();
    vectors++;
    if (phase !== 3'd1) begin
      miscompares++;
      $display("FAIL mid_ramp restart_phase: got %0d, want 1", phase);
    end
    tick_and_settle();
    vectors++;
    if (duty !== 4'd4) begin
      miscompares++;
      $display("FAIL mid_ramp restart_duty: got %0d, want 4", duty);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_full_cycle();
    test_edge_only();
    test_boundary_collision();
    test_disable_priority();
    test_reset_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
